// File: rtl/twpm_ram_pkg.sv
// Shared constants and types for the TwPM byte-enabled buffer RAM.
package twpm_ram_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/twpm_ram_be_array.sv
// Bare byte-enabled single-port array with a registered read port (latency 1).
// Same-address read-during-write behaviour is selected by RDW_MODE.
module twpm_ram_be_array
    import twpm_ram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       we_i,
    input  logic [DATA_W/BYTE_W-1:0]   be_i,
    input  logic                       re_i,
    output logic [DATA_W-1:0]          rdata_o
);

    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write port.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (we_i && be_i[i]) begin
                mem[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Registered read port; the array read stays inside the clocked block so it
    // maps onto the BRAM output latch. Write-first bypasses enabled lanes only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if ((RDW_MODE == RDW_WRITE_FIRST) && we_i && be_i[i]) begin
                    rdata_q[i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
                end else begin
                    rdata_q[i*BYTE_W +: BYTE_W] <= mem[addr_i][i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/twpm_ram_be_ctl.sv
// TwPM buffer RAM controller: post-reset clear sequencer, request gating,
// optional second read stage and read-valid pipeline around the array.
module twpm_ram_be_ctl
    import twpm_ram_pkg::*;
#(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned RDW_MODE     = RDW_READ_FIRST,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       we_i,
    input  logic [DATA_W/BYTE_W-1:0]   be_i,
    input  logic                       re_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rvalid_o,
    output logic                       ready_o
);

    localparam int unsigned NB = DATA_W / BYTE_W;

    if (DATA_W % BYTE_W != 0) begin : g_chk_data_w
        $error("twpm_ram_be_ctl: DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_rd_lat
        $error("twpm_ram_be_ctl: RD_LAT must be 1 or 2");
    end
    if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_chk_rdw
        $error("twpm_ram_be_ctl: RDW_MODE must be 0 or 1");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                vld1_q, vld1_d;
    logic                accept;

    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [NB-1:0]       arr_be;
    logic                arr_we;
    logic                arr_re;
    logic [DATA_W-1:0]   arr_rdata;

    // Next-state logic for the clear sequencer; ready follows the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: ;
            default: state_d = ST_RUN;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Requests in a reset cycle are dropped along with the pipeline.
    assign accept = ready_q && !rst_i;

    // Array port mux: clear sequencer owns the port while clearing.
    always_comb begin
        arr_addr  = addr_i;
        arr_wdata = wdata_i;
        arr_be    = be_i;
        arr_we    = we_i && accept;
        arr_re    = re_i && accept;
        if (state_q == ST_CLEAR) begin
            arr_addr  = cnt_q;
            arr_wdata = '0;
            arr_be    = '1;
            arr_we    = 1'b1;
            arr_re    = 1'b0;
        end
        vld1_d = arr_re;
    end

    // State, clear counter, ready and first valid stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            vld1_q  <= vld1_d;
        end
    end

    twpm_ram_be_array #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .re_i    (arr_re),
        .rdata_o (arr_rdata)
    );

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rdata2_q, rdata2_d;
        logic              vld2_q, vld2_d;

        // Second output stage captures only completed reads so data holds otherwise.
        always_comb begin
            rdata2_d = vld1_q ? arr_rdata : rdata2_q;
            vld2_d   = vld1_q;
        end

        // Second output stage registers.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata2_q <= '0;
                vld2_q   <= 1'b0;
            end else begin
                rdata2_q <= rdata2_d;
                vld2_q   <= vld2_d;
            end
        end

        assign rdata_o  = rdata2_q;
        assign rvalid_o = vld2_q;
    end else begin : g_lat1
        assign rdata_o  = arr_rdata;
        assign rvalid_o = vld1_q;
    end

    assign ready_o = ready_q;

endmodule

// File: tb/tb_twpm_ram_be_ctl.sv
// Directed bench: default instance (A), RD_LAT=2 write-first instance (B)
// sharing stimulus, plus a small no-clear instance (C).
module tb_twpm_ram_be_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  be = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, ready_a, ready_b;

    logic        rst_c = 1'b1;
    logic [3:0]  addr_c = '0;
    logic [15:0] wdata_c = '0;
    logic        we_c = 1'b0;
    logic        re_c = 1'b0;
    logic [1:0]  be_c = '0;
    logic [15:0] rdata_c;
    logic        rvalid_c, ready_c;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    twpm_ram_be_ctl u_dut_a (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we),
        .be_i(be), .re_i(re), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .ready_o(ready_a)
    );

    twpm_ram_be_ctl #(.RD_LAT(2), .RDW_MODE(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we),
        .be_i(be), .re_i(re), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .ready_o(ready_b)
    );

    twpm_ram_be_ctl #(.ADDR_W(4), .DATA_W(16), .CLEAR_ON_RST(0)) u_dut_c (
        .clk_i(clk), .rst_i(rst_c), .addr_i(addr_c), .wdata_i(wdata_c), .we_i(we_c),
        .be_i(be_c), .re_i(re_c), .rdata_o(rdata_c), .rvalid_o(rvalid_c), .ready_o(ready_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1;
        tick();
        we = 1'b0; be = '0;
    endtask

    // Single read: A answers after one edge, B after two.
    task automatic rd_chk(input string tag, input logic [8:0] a,
                          input logic [31:0] ea, input logic [31:0] eb);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        check({tag, "_a_vld"}, 32'(rvalid_a), 32'd1);
        check({tag, "_a_dat"}, rdata_a, ea);
        check({tag, "_b_early"}, 32'(rvalid_b), 32'd0);
        tick();
        check({tag, "_b_vld"}, 32'(rvalid_b), 32'd1);
        check({tag, "_b_dat"}, rdata_b, eb);
        check({tag, "_a_drop"}, 32'(rvalid_a), 32'd0);
    endtask

    initial begin
        int n;
        int stray;

        // Reset state
        tick();
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_ready_c", 32'(ready_c), 32'd0);
        rst = 1'b0;

        // Clear takes exactly 512 cycles
        n = 0;
        while (ready_a !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("clear_cycles", 32'(n), 32'd512);
        check("clear_ready_b", 32'(ready_b), 32'd1);

        rd_chk("rd0", 9'd0, 32'h0, 32'h0);
        rd_chk("rd255", 9'd255, 32'h0, 32'h0);
        rd_chk("rd511", 9'd511, 32'h0, 32'h0);

        // Byte lanes, and a zero byte-enable write is a no-op
        wr(9'd5, 32'hAABBCCDD, 4'b1111);
        wr(9'd5, 32'h11223344, 4'b0101);
        rd_chk("lanes", 9'd5, 32'hAA22CC44, 32'hAA22CC44);
        wr(9'd5, 32'h00000000, 4'b0000);
        rd_chk("be0", 9'd5, 32'hAA22CC44, 32'hAA22CC44);

        // Back-to-back pipelined reads
        wr(9'd1, 32'h1, 4'hF);
        wr(9'd2, 32'h2, 4'hF);
        wr(9'd3, 32'h3, 4'hF);
        re = 1'b1; addr = 9'd1;
        tick();
        check("pipe_a1", rdata_a, 32'h1);
        check("pipe_b_wait", 32'(rvalid_b), 32'd0);
        addr = 9'd2;
        tick();
        check("pipe_a2", rdata_a, 32'h2);
        check("pipe_b1_vld", 32'(rvalid_b), 32'd1);
        check("pipe_b1", rdata_b, 32'h1);
        addr = 9'd3;
        tick();
        re = 1'b0;
        check("pipe_a3", rdata_a, 32'h3);
        check("pipe_b2", rdata_b, 32'h2);
        tick();
        check("pipe_a_idle", 32'(rvalid_a), 32'd0);
        check("pipe_a_hold", rdata_a, 32'h3);
        check("pipe_b3_vld", 32'(rvalid_b), 32'd1);
        check("pipe_b3", rdata_b, 32'h3);
        tick();
        check("pipe_b_idle", 32'(rvalid_b), 32'd0);
        check("pipe_b_hold", rdata_b, 32'h3);

        // Read during write: A read-first, B write-first
        wr(9'd7, 32'h12345678, 4'hF);
        addr = 9'd7; wdata = 32'hFFFFFFFF; be = 4'b0011; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0; be = '0;
        check("rdw_a_vld", 32'(rvalid_a), 32'd1);
        check("rdw_a_old", rdata_a, 32'h12345678);
        tick();
        check("rdw_b_vld", 32'(rvalid_b), 32'd1);
        check("rdw_b_new", rdata_b, 32'h1234FFFF);
        rd_chk("rdw_after", 9'd7, 32'h1234FFFF, 32'h1234FFFF);

        // Reset part way through a clear restarts it
        wr(9'd400, 32'hDEADBEEF, 4'hF);
        rd_chk("pre_rst400", 9'd400, 32'hDEADBEEF, 32'hDEADBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr = 9'd3; wdata = 32'h55555555; be = 4'hF; we = 1'b1; re = 1'b1;
        stray = 0;
        repeat (100) begin
            tick();
            if (rvalid_a === 1'b1 || rvalid_b === 1'b1) stray++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (ready_a !== 1'b1 && n < 600) begin
            tick();
            n++;
            if (rvalid_a === 1'b1 || rvalid_b === 1'b1) stray++;
        end
        we = 1'b0; re = 1'b0; be = '0;
        check("reclear_cycles", 32'(n), 32'd512);
        check("clear_no_rvalid", 32'(stray), 32'd0);
        rd_chk("post_rst400", 9'd400, 32'h0, 32'h0);
        rd_chk("clear_wr_ignored", 9'd3, 32'h0, 32'h0);

        // No-clear small instance
        tick();
        check("c_in_rst_ready", 32'(ready_c), 32'd0);
        check("c_rst_rdata", 32'(rdata_c), 32'h0);
        rst_c = 1'b0;
        tick();
        check("c_ready", 32'(ready_c), 32'd1);
        addr_c = 4'd15; wdata_c = 16'hBEEF; be_c = 2'b11; we_c = 1'b1;
        tick();
        we_c = 1'b0;
        wdata_c = 16'h1234; be_c = 2'b10; we_c = 1'b1;
        tick();
        we_c = 1'b0; be_c = '0;
        re_c = 1'b1;
        tick();
        re_c = 1'b0;
        check("c_rvalid", 32'(rvalid_c), 32'd1);
        check("c_rdata", 32'(rdata_c), 32'h000012EF);
        addr_c = 4'd15; wdata_c = 16'hBEEF; be_c = 2'b11; we_c = 1'b1;
        tick();
        we_c = 1'b0; be_c = '0;
        re_c = 1'b1;
        tick();
        re_c = 1'b0;
        check("c_rdata_beef", 32'(rdata_c), 32'h0000BEEF);
        tick();
        check("c_rvalid_low", 32'(rvalid_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
